// File: rtl/ibex_rf_writeback.sv
// Write-side front end of the register file: merges ALU and buffered slow results onto one write port.
// Optional read bypass of the in-flight write is enabled by defining IBEX_RF_WB_FWD_EN.
module ibex_rf_writeback #(
  parameter bit          RV32E      = 1'b0,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alu_we_i,
  input  logic [4:0]            alu_waddr_i,
  input  logic [DATA_WIDTH-1:0] alu_wdata_i,
  input  logic                  slow_valid_i,
  output logic                  slow_ready_o,
  input  logic [4:0]            slow_waddr_i,
  input  logic [DATA_WIDTH-1:0] slow_wdata_i,
  input  logic                  issue_i,
  input  logic [4:0]            issue_waddr_i,
  input  logic [4:0]            raddr_a_i,
  input  logic [4:0]            raddr_b_i,
  output logic                  busy_a_o,
  output logic                  busy_b_o,
`ifdef IBEX_RF_WB_FWD_EN
  input  logic [DATA_WIDTH-1:0] rf_rdata_a_i,
  input  logic [DATA_WIDTH-1:0] rf_rdata_b_i,
  output logic [DATA_WIDTH-1:0] fwd_rdata_a_o,
  output logic [DATA_WIDTH-1:0] fwd_rdata_b_o,
`endif
  output logic [4:0]            rf_waddr_o,
  output logic [DATA_WIDTH-1:0] rf_wdata_o,
  output logic                  rf_we_o,
  output logic                  fifo_empty_o
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  function automatic logic addr_legal(input logic [4:0] addr);
    return (addr != 5'd0) && !(RV32E && addr[4]);
  endfunction

  logic [4:0]            fifo_addr_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wptr_q;
  logic [PTR_W-1:0]      rptr_q;
  logic [CNT_W-1:0]      count_q;

  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  push;
  logic                  pop;
  logic                  alu_sel;
  logic [4:0]            head_addr;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  head_write;

  logic [31:0]           busy_q;
  logic [31:0]           busy_d;

  assign fifo_full    = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty   = (count_q == '0);
  assign slow_ready_o = !fifo_full;
  assign fifo_empty_o = fifo_empty;

  assign head_addr  = fifo_addr_q[rptr_q];
  assign head_data  = fifo_data_q[rptr_q];

  // ALU writes to x0 or illegal registers must not block the slow path.
  assign alu_sel    = alu_we_i && addr_legal(alu_waddr_i);
  assign push       = slow_valid_i && !fifo_full;
  assign pop        = !fifo_empty && !alu_sel;
  assign head_write = pop && addr_legal(head_addr);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wptr_q] <= slow_waddr_i;
      fifo_data_q[wptr_q] <= slow_wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wptr_q <= wptr_q + PTR_W'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_o    <= 1'b0;
      rf_waddr_o <= '0;
      rf_wdata_o <= '0;
    end else if (alu_sel) begin
      rf_we_o    <= 1'b1;
      rf_waddr_o <= alu_waddr_i;
      rf_wdata_o <= alu_wdata_i;
    end else if (head_write) begin
      rf_we_o    <= 1'b1;
      rf_waddr_o <= head_addr;
      rf_wdata_o <= head_data;
    end else begin
      rf_we_o    <= 1'b0;
    end
  end

  // A newly issued op to the same register outranks the retiring write.
  always_comb begin
    busy_d = busy_q;
    if (head_write) begin
      busy_d[head_addr] = 1'b0;
    end
    if (issue_i && addr_legal(issue_waddr_i)) begin
      busy_d[issue_waddr_i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_a_o = (raddr_a_i != 5'd0) && busy_q[raddr_a_i];
  assign busy_b_o = (raddr_b_i != 5'd0) && busy_q[raddr_b_i];

`ifdef IBEX_RF_WB_FWD_EN
  assign fwd_rdata_a_o = (rf_we_o && (rf_waddr_o == raddr_a_i) && (raddr_a_i != 5'd0)) ?
                         rf_wdata_o : rf_rdata_a_i;
  assign fwd_rdata_b_o = (rf_we_o && (rf_waddr_o == raddr_b_i) && (raddr_b_i != 5'd0)) ?
                         rf_wdata_o : rf_rdata_b_i;
`endif

endmodule

// File: tb/tb_ibex_rf_writeback.sv
// Randomized and directed bench for ibex_rf_writeback against a queue-based reference model.
module tb_ibex_rf_writeback;
  localparam bit RV32E = 1'b1;
  localparam int DW    = 32;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          alu_we_i;
  logic [4:0]    alu_waddr_i;
  logic [DW-1:0] alu_wdata_i;
  logic          slow_valid_i;
  logic          slow_ready_o;
  logic [4:0]    slow_waddr_i;
  logic [DW-1:0] slow_wdata_i;
  logic          issue_i;
  logic [4:0]    issue_waddr_i;
  logic [4:0]    raddr_a_i;
  logic [4:0]    raddr_b_i;
  logic          busy_a_o;
  logic          busy_b_o;
  logic [4:0]    rf_waddr_o;
  logic [DW-1:0] rf_wdata_o;
  logic          rf_we_o;
  logic          fifo_empty_o;
`ifdef IBEX_RF_WB_FWD_EN
  logic [DW-1:0] rf_rdata_a_i;
  logic [DW-1:0] rf_rdata_b_i;
  logic [DW-1:0] fwd_rdata_a_o;
  logic [DW-1:0] fwd_rdata_b_o;
`endif

  ibex_rf_writeback #(.RV32E(RV32E), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_we_i(alu_we_i), .alu_waddr_i(alu_waddr_i), .alu_wdata_i(alu_wdata_i),
    .slow_valid_i(slow_valid_i), .slow_ready_o(slow_ready_o),
    .slow_waddr_i(slow_waddr_i), .slow_wdata_i(slow_wdata_i),
    .issue_i(issue_i), .issue_waddr_i(issue_waddr_i),
    .raddr_a_i(raddr_a_i), .raddr_b_i(raddr_b_i),
    .busy_a_o(busy_a_o), .busy_b_o(busy_b_o),
`ifdef IBEX_RF_WB_FWD_EN
    .rf_rdata_a_i(rf_rdata_a_i), .rf_rdata_b_i(rf_rdata_b_i),
    .fwd_rdata_a_o(fwd_rdata_a_o), .fwd_rdata_b_o(fwd_rdata_b_o),
`endif
    .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o), .rf_we_o(rf_we_o),
    .fifo_empty_o(fifo_empty_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]    a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          mq[$];
  bit            mbusy[32];
  logic          exp_we;
  logic [4:0]    exp_addr;
  logic [DW-1:0] exp_data;
  int            errors = 0;
  int            checks = 0;

  function automatic bit legal(input logic [4:0] a);
    return (a != 0) && !(RV32E && a[4]);
  endfunction

  function automatic bit exp_busy(input logic [4:0] a);
    return (a != 0) && mbusy[a];
  endfunction

  function automatic void model_reset();
    mq.delete();
    foreach (mbusy[i]) mbusy[i] = 0;
    exp_we = 0; exp_addr = 0; exp_data = 0;
  endfunction

  // Applies one clock edge's worth of the behavioural rules to the model.
  function automatic void model_edge();
    ent_t h;
    bit   accept = slow_valid_i && (mq.size() < DEPTH);
    int   clr = -1;
    if (alu_we_i && legal(alu_waddr_i)) begin
      exp_we = 1; exp_addr = alu_waddr_i; exp_data = alu_wdata_i;
    end else if (mq.size() > 0) begin
      h = mq.pop_front();
      if (legal(h.a)) begin
        exp_we = 1; exp_addr = h.a; exp_data = h.d; clr = int'(h.a);
      end else exp_we = 0;
    end else exp_we = 0;
    if (accept) mq.push_back('{slow_waddr_i, slow_wdata_i});
    if (clr >= 0) mbusy[clr] = 0;
    if (issue_i && legal(issue_waddr_i)) mbusy[issue_waddr_i] = 1;
  endfunction

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_we_i = 0; alu_waddr_i = 0; alu_wdata_i = 0;
    slow_valid_i = 0; slow_waddr_i = 0; slow_wdata_i = 0;
    issue_i = 0; issue_waddr_i = 0;
  endtask

  task automatic test_reset();
    rst_n = 1; idle_inputs(); raddr_a_i = 5; raddr_b_i = 0;
`ifdef IBEX_RF_WB_FWD_EN
    rf_rdata_a_i = 0; rf_rdata_b_i = 0;
`endif
    #2 rst_n = 0;
    model_reset();
    #1;
    checks++;
    if (rf_we_o !== 1'b0 || rf_waddr_o !== 5'd0 || rf_wdata_o !== '0) begin
      errors++; $display("FAIL reset_rf: we=%b addr=%0d data=%h required 0/0/0", rf_we_o, rf_waddr_o, rf_wdata_o);
    end
    checks++;
    if (fifo_empty_o !== 1'b1 || slow_ready_o !== 1'b1 || busy_a_o !== 1'b0) begin
      errors++; $display("FAIL reset_state: empty=%b ready=%b busy=%b required 1/1/0", fifo_empty_o, slow_ready_o, busy_a_o);
    end
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_alu_write();
    alu_we_i = 1; alu_waddr_i = 3; alu_wdata_i = 32'hDEADBEEF;
    tick();
    checks++;
    if (rf_we_o !== 1'b1 || rf_waddr_o !== 5'd3 || rf_wdata_o !== 32'hDEADBEEF) begin
      errors++; $display("FAIL alu_write: we=%b addr=%0d data=%h required 1/3/deadbeef", rf_we_o, rf_waddr_o, rf_wdata_o);
    end
    alu_waddr_i = 0; alu_wdata_i = 32'h0BADF00D;
    tick();
    checks++;
    if (rf_we_o !== 1'b0 || rf_waddr_o !== 5'd3 || rf_wdata_o !== 32'hDEADBEEF) begin
      errors++; $display("FAIL alu_x0: we=%b addr=%0d data=%h required 0/3/deadbeef", rf_we_o, rf_waddr_o, rf_wdata_o);
    end
    alu_waddr_i = 5'd20; alu_wdata_i = 32'h12345678;
    tick();
    checks++;
    if (rf_we_o !== 1'b0) begin
      errors++; $display("FAIL alu_illegal: we=%b required 0", rf_we_o);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_slow_latency();
    issue_i = 1; issue_waddr_i = 7; raddr_a_i = 7;
    tick();
    issue_i = 0;
    slow_valid_i = 1; slow_waddr_i = 7; slow_wdata_i = 32'h1234;
    #1;
    checks++;
    if (busy_a_o !== 1'b1 || slow_ready_o !== 1'b1) begin
      errors++; $display("FAIL slow_busy_set: busy=%b ready=%b required 1/1", busy_a_o, slow_ready_o);
    end
    tick();
    slow_valid_i = 0;
    #1;
    checks++;
    if (busy_a_o !== 1'b1 || rf_we_o !== 1'b0 || fifo_empty_o !== 1'b0) begin
      errors++; $display("FAIL slow_buffered: busy=%b we=%b empty=%b required 1/0/0", busy_a_o, rf_we_o, fifo_empty_o);
    end
    tick();
    checks++;
    if (rf_we_o !== 1'b1 || rf_waddr_o !== 5'd7 || rf_wdata_o !== 32'h1234 || busy_a_o !== 1'b0 || fifo_empty_o !== 1'b1) begin
      errors++; $display("FAIL slow_write: we=%b addr=%0d data=%h busy=%b empty=%b required 1/7/1234/0/1",
                         rf_we_o, rf_waddr_o, rf_wdata_o, busy_a_o, fifo_empty_o);
    end
    tick();
  endtask

  task automatic test_backpressure();
    int          pushed = 0;
    logic [DW-1:0] seen[$];
    for (int i = 0; i < 10; i++) begin
      alu_we_i = 1; alu_waddr_i = 5'(1 + (i % 15)); alu_wdata_i = 32'hA000 + i;
      slow_valid_i = (pushed < 3); slow_waddr_i = 5'(10 + pushed); slow_wdata_i = 32'hB000 + pushed;
      #1;
      checks++;
      if (slow_ready_o !== (pushed < 2)) begin
        errors++; $display("FAIL bp_ready cycle %0d: ready=%b required %b", i, slow_ready_o, pushed < 2);
      end
      if (slow_valid_i && slow_ready_o) pushed++;
      tick();
      checks++;
      if (rf_we_o !== 1'b1 || rf_wdata_o !== 32'hA000 + i) begin
        errors++; $display("FAIL bp_alu cycle %0d: we=%b data=%h required 1/%h", i, rf_we_o, rf_wdata_o, 32'hA000 + i);
      end
    end
    alu_we_i = 0;
    for (int i = 0; i < 8 && seen.size() < 3; i++) begin
      slow_valid_i = (pushed < 3); slow_waddr_i = 5'(10 + pushed); slow_wdata_i = 32'hB000 + pushed;
      #1;
      if (slow_valid_i && slow_ready_o) pushed++;
      tick();
      if (rf_we_o) seen.push_back(rf_wdata_o);
    end
    slow_valid_i = 0;
    checks++;
    if (seen.size() != 3 || seen[0] !== 32'hB000 || seen[1] !== 32'hB001 || seen[2] !== 32'hB002) begin
      errors++; $display("FAIL bp_drain_order: got %0d writes %p required B000 B001 B002", seen.size(), seen);
    end
    checks++;
    if (slow_ready_o !== 1'b1 || fifo_empty_o !== 1'b1) begin
      errors++; $display("FAIL bp_after_drain: ready=%b empty=%b required 1/1", slow_ready_o, fifo_empty_o);
    end
  endtask

  task automatic test_collision();
    issue_i = 1; issue_waddr_i = 9; raddr_b_i = 9;
    tick();
    issue_i = 0; slow_valid_i = 1; slow_waddr_i = 9; slow_wdata_i = 32'h99;
    tick();
    slow_valid_i = 0; issue_i = 1; issue_waddr_i = 9;
    tick();
    issue_i = 0;
    #1;
    checks++;
    if (rf_we_o !== 1'b1 || rf_waddr_o !== 5'd9 || busy_b_o !== 1'b1) begin
      errors++; $display("FAIL collision: we=%b addr=%0d busy=%b required 1/9/1", rf_we_o, rf_waddr_o, busy_b_o);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      alu_we_i      = ($urandom_range(0, 99) < 55);
      alu_waddr_i   = 5'($urandom_range(0, 31));
      alu_wdata_i   = $urandom;
      slow_valid_i  = ($urandom_range(0, 99) < 50);
      slow_waddr_i  = 5'($urandom_range(0, 31));
      slow_wdata_i  = $urandom;
      issue_i       = ($urandom_range(0, 99) < 35);
      issue_waddr_i = 5'($urandom_range(0, 31));
      raddr_a_i     = 5'($urandom_range(0, 31));
      raddr_b_i     = 5'($urandom_range(0, 31));
      #1;
      checks++;
      if (slow_ready_o !== (mq.size() < DEPTH) || fifo_empty_o !== (mq.size() == 0) ||
          busy_a_o !== exp_busy(raddr_a_i) || busy_b_o !== exp_busy(raddr_b_i)) begin
        errors++; $display("FAIL rand_comb %0d: ready=%b empty=%b busy_a=%b busy_b=%b required %b/%b/%b/%b", i,
                           slow_ready_o, fifo_empty_o, busy_a_o, busy_b_o,
                           mq.size() < DEPTH, mq.size() == 0, exp_busy(raddr_a_i), exp_busy(raddr_b_i));
      end
      tick();
      checks++;
      if (rf_we_o !== exp_we || rf_waddr_o !== exp_addr || rf_wdata_o !== exp_data) begin
        errors++; $display("FAIL rand_rf %0d: we=%b addr=%0d data=%h required %b/%0d/%h", i,
                           rf_we_o, rf_waddr_o, rf_wdata_o, exp_we, exp_addr, exp_data);
      end
    end
    idle_inputs();
    repeat (3) tick();
  endtask

  task automatic test_reset_mid();
    alu_we_i = 1; alu_waddr_i = 1; alu_wdata_i = 32'h1;
    issue_i = 1; issue_waddr_i = 5; raddr_a_i = 5;
    slow_valid_i = 1; slow_waddr_i = 5; slow_wdata_i = 32'h55;
    tick();
    issue_i = 0; slow_wdata_i = 32'h56;
    tick();
    slow_valid_i = 0;
    #1;
    checks++;
    if (fifo_empty_o !== 1'b0 || slow_ready_o !== 1'b0 || busy_a_o !== 1'b1) begin
      errors++; $display("FAIL reset_mid_pre: empty=%b ready=%b busy=%b required 0/0/1", fifo_empty_o, slow_ready_o, busy_a_o);
    end
    rst_n = 0;
    model_reset();
    #1;
    checks++;
    if (rf_we_o !== 1'b0 || fifo_empty_o !== 1'b1 || slow_ready_o !== 1'b1 || busy_a_o !== 1'b0) begin
      errors++; $display("FAIL reset_mid: we=%b empty=%b ready=%b busy=%b required 0/1/1/0",
                         rf_we_o, fifo_empty_o, slow_ready_o, busy_a_o);
    end
    idle_inputs();
    #1 rst_n = 1;
    tick();
    checks++;
    if (rf_we_o !== 1'b0 || fifo_empty_o !== 1'b1) begin
      errors++; $display("FAIL reset_mid_after: we=%b empty=%b required 0/1", rf_we_o, fifo_empty_o);
    end
  endtask

`ifdef IBEX_RF_WB_FWD_EN
  task automatic test_fwd();
    alu_we_i = 1; alu_waddr_i = 4; alu_wdata_i = 32'hA5A5A5A5;
    tick();
    idle_inputs();
    raddr_a_i = 4; rf_rdata_a_i = 0; raddr_b_i = 6; rf_rdata_b_i = 32'h66;
    #1;
    checks++;
    if (fwd_rdata_a_o !== 32'hA5A5A5A5 || fwd_rdata_b_o !== 32'h66) begin
      errors++; $display("FAIL fwd_hit: a=%h b=%h required a5a5a5a5/66", fwd_rdata_a_o, fwd_rdata_b_o);
    end
    raddr_a_i = 0; rf_rdata_a_i = 32'h1111;
    #1;
    checks++;
    if (fwd_rdata_a_o !== 32'h1111) begin
      errors++; $display("FAIL fwd_x0: a=%h required 1111", fwd_rdata_a_o);
    end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_alu_write();
    test_slow_latency();
    test_backpressure();
    test_collision();
    test_random();
    test_reset_mid();
`ifdef IBEX_RF_WB_FWD_EN
    test_fwd();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach its summary");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/ibex_rf_writeback.md
Name: ibex_rf_writeback

Overview:
- Write-side front end for the flip-flop register file; owns its single write port (waddr/wdata/we).
- Merges two result producers into that port:
  - single-cycle ALU path, which has priority and never stalls;
  - multi-cycle LSU/mult-div path, using a valid/ready handshake and buffered in a small FIFO.
- Keeps a per-register busy scoreboard for outstanding slow results, so decode can stall on RAW hazards.

Parameters:
- RV32E, 0, 1 = 16 architectural registers; write addresses with bit 4 set are dropped and never marked busy.
- DATA_WIDTH, 32, result/register width.
- FIFO_DEPTH, 2, slow-result buffer entries (power of two, >=2).

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- alu_we_i  input  1  ALU result valid this cycle
- alu_waddr_i  input  5  ALU destination register
- alu_wdata_i  input  DATA_WIDTH  ALU result
- slow_valid_i  input  1  slow-path result valid
- slow_ready_o  output  1  FIFO can accept a slow result
- slow_waddr_i  input  5  slow-path destination register
- slow_wdata_i  input  DATA_WIDTH  slow-path result
- issue_i  input  1  a slow-path op is issued this cycle
- issue_waddr_i  input  5  destination register of the issued slow op
- raddr_a_i  input  5  decode read address A (scoreboard lookup)
- raddr_b_i  input  5  decode read address B
- busy_a_o  output  1  register raddr_a_i has an outstanding slow write
- busy_b_o  output  1  register raddr_b_i has an outstanding slow write
- rf_waddr_o  output  5  to register file waddr_a_i
- rf_wdata_o  output  DATA_WIDTH  to register file wdata_a_i
- rf_we_o  output  1  to register file we_a_i
- fifo_empty_o  output  1  no buffered slow results

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values:
  - rf_we_o = 0, rf_waddr_o = 0, rf_wdata_o = 0;
  - FIFO emptied, so fifo_empty_o = 1 and slow_ready_o = 1;
  - all scoreboard busy bits cleared.
- Reset mid-operation discards buffered results and pending busy bits.
- Output stage is registered. rf_* update every edge:
  - ALU selected: rf_we_o=1, ALU address/data;
  - else FIFO head selected: rf_we_o=1, head address/data, head popped;
  - else rf_we_o=0, rf_waddr_o/rf_wdata_o hold their previous values.
- Priority: alu_we_i=1 with a legal, nonzero address always wins. FIFO head waits while the ALU writes every cycle.
- Dropped writes:
  - address x0, or bit 4 set when RV32E=1;
  - never drive rf_we_o;
  - an ALU write to x0 does not block the FIFO that cycle;
  - a slow result to x0 is still accepted and popped, with no write issued.
- ALU latency: sampled at edge N, rf_we_o high during cycle N..N+1.
- Slow path:
  - handshake completes when slow_valid_i && slow_ready_o at an edge;
  - slow_ready_o = !full, combinational from FIFO state only (no pop-through when full);
  - no FIFO bypass: a result accepted at edge N is at the head in cycle N+1;
  - earliest write is rf_we_o high after edge N+1 (2-edge latency).
- FIFO: in-order, circular pointers with wrap-around. Simultaneous push and pop on a non-full FIFO keeps the count unchanged.
- Scoreboard:
  - busy[r] set at the edge where issue_i=1 and issue_waddr_i=r (x0 and illegal addresses ignored);
  - cleared at the edge where the slow write to r is loaded into the output stage;
  - set and clear of the same register in one cycle: set wins (a new op was issued);
  - busy_a_o/busy_b_o are combinational from busy[raddr]; x0 always reads 0.
- Same-address ALU and slow writes are serialized by priority. Ordering correctness is the issuer's duty (decode stalls on busy).

Optional Feature:
- Macro: IBEX_RF_WB_FWD_EN.
- When defined, adds:
  - inputs rf_rdata_a_i and rf_rdata_b_i (DATA_WIDTH), taken from the register file;
  - outputs fwd_rdata_a_o and fwd_rdata_b_o (DATA_WIDTH).
- Each fwd output:
  - = rf_wdata_o when rf_we_o && rf_waddr_o == raddr && raddr != 0;
  - otherwise = the matching rf_rdata input.
  - This hides the write-then-read cycle.
- When undefined: those ports are absent; no bypass logic.

Test Plan:
- Reset:
  - Stimulus: assert rst_n=0 asynchronously mid-cycle, with 2 entries in the FIFO and x5 busy.
  - Required: immediately rf_we_o=0, fifo_empty_o=1, slow_ready_o=1, busy for x5 reads 0.
- ALU write:
  - Stimulus: alu_we_i=1, addr 3, data 0xDEADBEEF at edge N.
  - Required: cycle N+1 shows rf_we_o=1, rf_waddr_o=3, rf_wdata_o=0xDEADBEEF.
  - Stimulus: ALU write to addr 0.
  - Required: rf_we_o=0.
- Slow result latency:
  - Stimulus: issue_i for x7; slow result x7 = 0x1234 accepted at edge N; ALU idle.
  - Required: busy_a_o=1 (raddr_a_i=7) until edge N+1; rf_we_o=1 with data 0x1234 after edge N+1; busy clears at edge N+1.
- Backpressure and starvation:
  - Stimulus: ALU writes every cycle for 10 cycles while the slow path pushes 3 results.
  - Required: slow_ready_o drops after 2 accepts; the 3rd result is held; when the ALU idles, FIFO drains in order, one per cycle, then slow_ready_o=1.
- Set/clear collision:
  - Stimulus: the slow write to x9 pops in the same cycle that issue_i marks x9.
  - Required: busy[9] remains 1 afterwards.
- With IBEX_RF_WB_FWD_EN:
  - Stimulus: rf_we_o=1, rf_waddr_o=4, rf_wdata_o=0xA5A5A5A5, raddr_a_i=4, rf_rdata_a_i=0.
  - Required: fwd_rdata_a_o=0xA5A5A5A5.
  - Stimulus: raddr_a_i=0.
  - Required: fwd_rdata_a_o = rf_rdata_a_i.
